vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator that produces DrawX, DrawY, blank, hs and vs for the 640x480@60 Hz display path.
- Sits directly upstream of every sprite/background mapper. Mappers consume DrawX/DrawY to form ROM addresses and use blank (1 = visible) to gate RGB.
- Also provides a frame-start pulse and a free-running frame counter, which sprite animation logic uses to step frames.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current pixel column 0..H_TOTAL-1
- DrawY  out  10  current line 0..V_TOTAL-1
- blank  out  1  1 = (DrawX,DrawY) visible, 0 = porch/sync
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- sync  out  1  composite sync, constant 0
- frame_start  out  1  one-cycle pulse while (DrawX,DrawY) = (0,0)
- frame_count  out  8  frame index, wraps 255 -> 0

Behaviour:
- Totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default).
  - Both must be ≤1024; this is checked by an elaboration-time assertion.
- Counters: DrawX and DrawY are the counter registers themselves, not copies.
  - DrawX increments every vga_clk and wraps H_TOTAL-1 -> 0.
  - DrawY increments only when DrawX wraps, and wraps V_TOTAL-1 -> 0 on the same edge that DrawX wraps.
- Decode: hs, vs, blank and frame_start are flops loaded from the next-state counter values.
  - They therefore always describe the same (DrawX,DrawY) as presented in the same cycle.
  - They are glitch-free.
- Decode ranges:
  - blank=1 iff X<H_VISIBLE and Y<V_VISIBLE.
  - hs=0 iff H_VISIBLE+H_FP ≤ X < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FP ≤ Y < V_VISIBLE+V_FP+V_SYNC (490..491).
- frame_start=1 iff X=0 and Y=0.
- frame_count increments on the same edge that loads frame_start=1, i.e. the first cycle of each frame already shows the new index.
- Reset: reset is sampled on vga_clk and dominates all other updates. While reset is high:
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1.
  - blank=0, hs=1, vs=1, frame_start=0, frame_count=8'hFF.
- First edge with reset low:
  - DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=0.
  - So the first frame after reset is frame 0.
- Reset mid-frame: counters jump to the reset values on the next edge; no partial-line completion. frame_count returns to 8'hFF.
- Output latency: 0 cycles between counter value and its decode. Frame period is H_TOTAL*V_TOTAL = 420000 cycles.

Optional Feature:
- Macro VGA_SYNC_ALIGN_EN compensates for the mapper pipeline (ROM read register plus RGB output register).
- When VGA_SYNC_ALIGN_EN is defined:
  - hs and vs are delayed by exactly 2 vga_clk cycles.
  - blank is delayed by exactly 1 cycle.
  - DrawX, DrawY, frame_start and frame_count are undelayed.
  - Delay-stage reset values: hs=1, vs=1, blank=0.
  - Result: the monitor sees sync edges aligned to the pixel actually registered by the mappers.
- When VGA_SYNC_ALIGN_EN is not defined: all outputs are aligned to DrawX/DrawY as specified above.

Test Plan:
- Reset held 3 cycles, then released -> during reset DrawX=799, DrawY=524, hs=vs=1, blank=0, frame_count=FF. First edge after release: DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=0.
- Run one line from (0,0) -> blank=1 for X=0..639, 0 for X=640..799. hs=0 exactly for X=656..751 (96 cycles). At X=799->0, DrawY becomes 1.
- Run a full frame -> vs=0 exactly for Y=490..491 (1600 cycles). blank=0 for all Y≥480. Next frame_start occurs 420000 cycles after the previous one, with frame_count=1.
- Run 256 frames -> frame_count wraps 255 -> 0 on the frame_start edge. Exactly one frame_start pulse per frame.
- Assert reset at (DrawX=300, DrawY=200) for 1 cycle -> next edge DrawX=799, DrawY=524, frame_count=FF. Following edge: (0,0) with frame_start=1.
- With VGA_SYNC_ALIGN_EN -> first hs low at DrawX=658. blank falls at DrawX=641. DrawX/DrawY timing is unchanged from the non-macro build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY counters with registered blank/hs/vs decode.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs by 2 and blank by 1 pixel clock.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range
    $error("vga_timing_gen: raster totals exceed 10-bit counters");
  end

  localparam logic [10:0] X_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] Y_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_MAX  = 10'(V_TOTAL - 1);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       blank_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       fs_nxt;
  logic       blank_q;
  logic       hs_q;
  logic       vs_q;

  always_comb begin
    x_nxt = DrawX + 10'd1;
    y_nxt = DrawY;
    if (DrawX == X_MAX) begin
      x_nxt = '0;
      y_nxt = (DrawY == Y_MAX) ? '0 : DrawY + 10'd1;
    end
  end

  // Decode the upcoming position so the flops line up with the counters.
  assign blank_nxt = ({1'b0, x_nxt} < X_VIS) && ({1'b0, y_nxt} < Y_VIS);
  assign hs_nxt = !(({1'b0, x_nxt} >= HS_BEG) && ({1'b0, x_nxt} < HS_END));
  assign vs_nxt = !(({1'b0, y_nxt} >= VS_BEG) && ({1'b0, y_nxt} < VS_END));
  assign fs_nxt = (x_nxt == '0) && (y_nxt == '0);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= X_MAX;
      DrawY       <= Y_MAX;
      blank_q     <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 8'hFF;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      blank_q     <= blank_nxt;
      hs_q        <= hs_nxt;
      vs_q        <= vs_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt)
        frame_count <= frame_count + 8'd1;
    end
  end

  assign sync = 1'b0;

`ifdef VGA_SYNC_ALIGN_EN
  // Match the mapper's ROM and RGB register stages.
  logic hs_d1;
  logic hs_d2;
  logic vs_d1;
  logic vs_d2;
  logic blank_d1;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_d1    <= 1'b1;
      hs_d2    <= 1'b1;
      vs_d1    <= 1'b1;
      vs_d2    <= 1'b1;
      blank_d1 <= 1'b0;
    end else begin
      hs_d1    <= hs_q;
      hs_d2    <= hs_d1;
      vs_d1    <= vs_q;
      vs_d2    <= vs_d1;
      blank_d1 <= blank_q;
    end
  end

  assign hs    = hs_d2;
  assign vs    = vs_d2;
  assign blank = blank_d1;
`else
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default raster for line timing,
// a reduced raster for frame-level, wrap and mid-frame reset behaviour.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int HD = 2;
  localparam int BD = 1;
`else
  localparam int HD = 0;
  localparam int BD = 0;
`endif

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       d_rst = 1'b1;
  logic [9:0] d_x, d_y;
  logic       d_blank, d_hs, d_vs, d_sync, d_fs;
  logic [7:0] d_fc;

  logic       s_rst = 1'b1;
  logic [9:0] s_x, s_y;
  logic       s_blank, s_hs, s_vs, s_sync, s_fs;
  logic [7:0] s_fc;

  vga_timing_gen dut (
    .vga_clk(vga_clk), .reset(d_rst),
    .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .sync(d_sync),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // 15 x 10 raster: hs low X=10..12, vs low Y=7..8, 150 cycles/frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) sml (
    .vga_clk(vga_clk), .reset(s_rst),
    .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .sync(s_sync),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  vec_t tbl[6];
  int ex, ey, efc, nfs, last_fs, vlow, bhigh, hlow, hs_first, bl_fall;
  int hx[3];
  int hy[3];

  initial begin
    tbl[0] = '{1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[1] = '{1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[2] = '{1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[3] = '{1'b0, 10'd0, 10'd0, (BD == 0), 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[4] = '{1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 6; i++) begin
      d_rst = tbl[i].rst;
      step();
      chk($sformatf("v%0d_x", i), d_x, tbl[i].x);
      chk($sformatf("v%0d_y", i), d_y, tbl[i].y);
      chk($sformatf("v%0d_blank", i), d_blank, tbl[i].blank);
      chk($sformatf("v%0d_hs", i), d_hs, tbl[i].hs);
      chk($sformatf("v%0d_vs", i), d_vs, tbl[i].vs);
      chk($sformatf("v%0d_fs", i), d_fs, tbl[i].fs);
      chk($sformatf("v%0d_fc", i), d_fc, tbl[i].fc);
      chk($sformatf("v%0d_sync", i), d_sync, 0);
    end

    // Rest of line 0 on the full-size raster.
    ex = 2; ey = 0;
    hx = '{2, 1, 0};
    hy = '{0, 0, 0};
    hlow = 0; hs_first = -1; bl_fall = -1;
    for (int c = 0; c < 798; c++) begin
      step();
      ex++;
      if (ex == 800) begin ex = 0; ey++; end
      hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = ex;
      hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = ey;
      chk("line_x", d_x, ex);
      chk("line_y", d_y, ey);
      chk("line_blank", d_blank, (hx[BD] < 640) && (hy[BD] < 480));
      chk("line_hs", d_hs, !(hx[HD] >= 656 && hx[HD] < 752));
      chk("line_fs", d_fs, 0);
      if (!d_hs) begin
        hlow++;
        if (hs_first < 0) hs_first = ex;
      end
      if (!d_blank && bl_fall < 0) bl_fall = ex;
    end
    chk("line_hs_width", hlow, 96);
    chk("line_hs_first", hs_first, 656 + HD);
    chk("line_blank_fall", bl_fall, 640 + BD);
    chk("line_wrap_y", d_y, 1);

    // Small raster: reset, then 256 frames.
    step();
    step();
    chk("s_rst_x", s_x, 14);
    chk("s_rst_y", s_y, 9);
    chk("s_rst_fc", s_fc, 8'hFF);
    chk("s_rst_hs", s_hs, 1);
    chk("s_rst_vs", s_vs, 1);
    chk("s_rst_blank", s_blank, 0);
    s_rst = 1'b0;
    step();
    ex = 0; ey = 0; efc = 0;
    chk("s_first_x", s_x, 0);
    chk("s_first_y", s_y, 0);
    chk("s_first_fs", s_fs, 1);
    chk("s_first_fc", s_fc, 0);
    nfs = 0; last_fs = 0; vlow = 0; bhigh = 0;
    for (int c = 1; c <= 256 * 150; c++) begin
      step();
      ex++;
      if (ex == 15) begin
        ex = 0;
        ey++;
        if (ey == 10) ey = 0;
      end
      if (ex == 0 && ey == 0) efc = (efc + 1) % 256;
      chk("s_x", s_x, ex);
      chk("s_y", s_y, ey);
      chk("s_fs", s_fs, (ex == 0 && ey == 0));
      chk("s_fc", s_fc, efc);
      if (s_fs) begin
        nfs++;
        chk("s_period", c - last_fs, 150);
        last_fs = c;
      end
      if (efc == 1) begin
        if (!s_vs) vlow++;
        if (s_blank) bhigh++;
      end
    end
    chk("s_fs_count", nfs, 256);
    chk("s_vs_width", vlow, 30);
    chk("s_blank_cycles", bhigh, 48);
    chk("s_fc_wrap", s_fc, 0);

    // Mid-frame reset at (5,4).
    for (int c = 0; c < 65; c++) step();
    chk("s_mid_x", s_x, 5);
    chk("s_mid_y", s_y, 4);
    s_rst = 1'b1;
    step();
    chk("s_mr_x", s_x, 14);
    chk("s_mr_y", s_y, 9);
    chk("s_mr_fc", s_fc, 8'hFF);
    chk("s_mr_fs", s_fs, 0);
    chk("s_mr_blank", s_blank, 0);
    s_rst = 1'b0;
    step();
    chk("s_rel_x", s_x, 0);
    chk("s_rel_y", s_y, 0);
    chk("s_rel_fs", s_fs, 1);
    chk("s_rel_fc", s_fc, 0);
    chk("s_sync", s_sync, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
